// File: rtl/sprite_pkg.sv
// Shared constants for the sprite fetchers (frog, car, log).
package sprite_pkg;

    localparam int unsigned SPRITE_W = 32;
    localparam int unsigned SPRITE_H = 32;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COLOR_W  = 9;
    localparam int unsigned COL_W    = $clog2(SPRITE_W);
    localparam int unsigned ROW_W    = $clog2(SPRITE_H);

    // Colour key meaning "no pixel here".
    localparam logic [COLOR_W-1:0] TRANSPARENT = 9'b111000111;

    // RGB333 field offsets within a pixel word.
    localparam int unsigned RED_LSB   = 6;
    localparam int unsigned GREEN_LSB = 3;
    localparam int unsigned BLUE_LSB  = 0;

    function automatic logic is_opaque(input logic [COLOR_W-1:0] color);
        return color != TRANSPARENT;
    endfunction

endpackage

// File: rtl/sprite_fetch_frog_if.sv
// Sprite memory read bus plus the pixel stream towards the mixer.
interface sprite_fetch_frog_if;
    import sprite_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic [COLOR_W-1:0] pix_out;
    logic               pix_valid;

    // Fetcher side.
    modport master (
        output mem_addr,
        input  mem_data,
        output pix_out,
        output pix_valid
    );

    // Memory / mixer side.
    modport slave (
        input  mem_addr,
        output mem_data,
        input  pix_out,
        input  pix_valid
    );

endinterface

// File: rtl/sprite_hit_calc.sv
// Combinational sprite hit test with row/column and optional horizontal mirror.
// Bounds use one extra bit so a sprite near the right/bottom edge never wraps.
module sprite_hit_calc #(
    parameter int unsigned SPR_W = 32,
    parameter int unsigned SPR_H = 32,
    parameter int unsigned CRD_W = 10,
    localparam int unsigned CW   = $clog2(SPR_W),
    localparam int unsigned RW   = $clog2(SPR_H)
) (
    input  logic             i_armed,
    input  logic             i_pix_en,
    input  logic [CRD_W-1:0] i_h_cnt,
    input  logic [CRD_W-1:0] i_v_cnt,
    input  logic [CRD_W-1:0] i_lx,
    input  logic [CRD_W-1:0] i_ly,
    input  logic             i_flip,
    output logic             o_hit,
    output logic [RW-1:0]    o_row,
    output logic [CW-1:0]    o_col
);

    logic [CRD_W:0] w_h;
    logic [CRD_W:0] w_v;
    logic [CRD_W:0] w_x_lo;
    logic [CRD_W:0] w_x_hi;
    logic [CRD_W:0] w_y_lo;
    logic [CRD_W:0] w_y_hi;
    logic           w_in_x;
    logic           w_in_y;
    logic [CW-1:0]  w_col_raw;

    assign w_h    = {1'b0, i_h_cnt};
    assign w_v    = {1'b0, i_v_cnt};
    assign w_x_lo = {1'b0, i_lx};
    assign w_y_lo = {1'b0, i_ly};
    assign w_x_hi = w_x_lo + (CRD_W+1)'(SPR_W);
    assign w_y_hi = w_y_lo + (CRD_W+1)'(SPR_H);

    assign w_in_x = (w_h >= w_x_lo) && (w_h < w_x_hi);
    assign w_in_y = (w_v >= w_y_lo) && (w_v < w_y_hi);
    assign o_hit  = i_armed && i_pix_en && w_in_x && w_in_y;

    assign w_col_raw = CW'(i_h_cnt - i_lx);
    assign o_col     = i_flip ? (CW'(SPR_W - 1) - w_col_raw) : w_col_raw;
    assign o_row     = RW'(i_v_cnt - i_ly);

endmodule

// File: rtl/sprite_fetch_frog.sv
// Frog sprite fetcher: per-frame position latch, hit test, memory address
// issue and a 3-cycle aligned, colour-keyed pixel output.
module sprite_fetch_frog
    import sprite_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               flip_x,
    input  logic [COORD_W-1:0] h_cnt,
    input  logic [COORD_W-1:0] v_cnt,
    input  logic               pix_en,
    sprite_fetch_frog_if.master bus
);

    logic [COORD_W-1:0] r_lx;
    logic [COORD_W-1:0] r_ly;
    logic               r_flip;
    logic               r_armed;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_hit_d1;
    logic               r_hit_d2;
    logic [COLOR_W-1:0] r_pix_out;
    logic               r_pix_valid;

    logic               w_hit;
    logic [ROW_W-1:0]   w_row;
    logic [COL_W-1:0]   w_col;

    // Latch position/orientation once per frame; the hit test in the
    // frame_start cycle still sees the previous values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lx    <= '0;
            r_ly    <= '0;
            r_flip  <= 1'b0;
            r_armed <= 1'b0;
        end else if (frame_start) begin
            r_lx    <= pos_x;
            r_ly    <= pos_y;
            r_flip  <= flip_x;
            r_armed <= 1'b1;
        end
    end

    sprite_hit_calc #(
        .SPR_W (SPRITE_W),
        .SPR_H (SPRITE_H),
        .CRD_W (COORD_W)
    ) u_hit_calc (
        .i_armed  (r_armed),
        .i_pix_en (pix_en),
        .i_h_cnt  (h_cnt),
        .i_v_cnt  (v_cnt),
        .i_lx     (r_lx),
        .i_ly     (r_ly),
        .i_flip   (r_flip),
        .o_hit    (w_hit),
        .o_row    (w_row),
        .o_col    (w_col)
    );

    // Stage 1: issue the sprite address on a hit, otherwise hold it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem_addr <= '0;
            r_hit_d1   <= 1'b0;
        end else begin
            if (w_hit) begin
                r_mem_addr <= {w_row, w_col};
            end
            r_hit_d1 <= w_hit;
        end
    end

    // Stage 2: memory read in flight; carry the hit flag alongside it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hit_d2 <= 1'b0;
        end else begin
            r_hit_d2 <= r_hit_d1;
        end
    end

    // Stage 3: colour-key the returned data and register the output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pix_valid <= 1'b0;
            r_pix_out   <= '0;
        end else if (r_hit_d2 && is_opaque(bus.mem_data)) begin
            r_pix_valid <= 1'b1;
            r_pix_out   <= bus.mem_data;
        end else begin
            r_pix_valid <= 1'b0;
            r_pix_out   <= '0;
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.pix_out   = r_pix_out;
    assign bus.pix_valid = r_pix_valid;

endmodule

// File: tb/tb_sprite_fetch_frog.sv
// Bench for sprite_fetch_frog: constant-expectation probe table, hand
// sequences for latch/reset corners, and random raster against a model.
module tb_sprite_fetch_frog;
    import sprite_pkg::*;

    localparam logic [8:0] GRN = 9'b000111000;
    localparam logic [8:0] BLU = 9'b000000111;
    localparam logic [8:0] RED = 9'b111000000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       frame_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       flip_x;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       pix_en;

    sprite_fetch_frog_if bus ();

    sprite_fetch_frog dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_x      (flip_x),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .pix_en      (pix_en),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read sprite memory, one cycle latency.
    logic [8:0] mem [1024];
    always @(posedge CLK) bus.mem_data <= mem[bus.mem_addr];

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int   m_lx, m_ly, m_addr;
    logic m_flip, m_armed;
    int   pv [3];
    int   pp [3];

    typedef struct {
        logic lat;
        int   px;
        int   py;
        logic fl;
        int   h;
        int   v;
        logic en;
        int   ea;
        int   ev;
        int   ep;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_lx = 0; m_ly = 0; m_flip = 1'b0; m_armed = 1'b0; m_addr = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 0;
            pp[i] = 0;
        end
    endtask

    // One pixel clock: drive inputs, predict, clock, compare every output.
    task automatic run_cycle(input logic fs, input int px, input int py, input logic fl,
                             input int h, input int v, input logic en);
        int   hh, vv, col, row, a, nv, np;
        logic hit;
        hh = h & 1023;
        vv = v & 1023;
        frame_start = fs;
        pos_x  = 10'(px & 1023);
        pos_y  = 10'(py & 1023);
        flip_x = fl;
        h_cnt  = 10'(hh);
        v_cnt  = 10'(vv);
        pix_en = en;
        hit = m_armed && en && hh >= m_lx && hh < m_lx + 32 && vv >= m_ly && vv < m_ly + 32;
        col = hh - m_lx;
        if (m_flip) col = 31 - col;
        row = vv - m_ly;
        a   = row * 32 + col;
        nv = 0;
        np = 0;
        if (hit && mem[a & 1023] != TRANSPARENT) begin
            nv = 1;
            np = int'(mem[a & 1023]);
        end
        if (fs) begin
            m_lx = px & 1023; m_ly = py & 1023; m_flip = fl; m_armed = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (hit) m_addr = a;
        pv[2] = pv[1]; pp[2] = pp[1];
        pv[1] = pv[0]; pp[1] = pp[0];
        pv[0] = nv;    pp[0] = np;
        chk("model_mem_addr", int'(bus.mem_addr), m_addr);
        chk("model_pix_valid", int'(bus.pix_valid), pv[2]);
        chk("model_pix_out", int'(bus.pix_out), pp[2]);
    endtask

    task automatic probe(input vec_t t);
        if (t.lat) run_cycle(1'b1, t.px, t.py, t.fl, 0, 0, 1'b0);
        run_cycle(1'b0, t.px, t.py, t.fl, t.h, t.v, t.en);
        chk("tbl_mem_addr", int'(bus.mem_addr), t.ea);
        run_cycle(1'b0, t.px, t.py, t.fl, 0, 0, 1'b0);
        run_cycle(1'b0, t.px, t.py, t.fl, 0, 0, 1'b0);
        chk("tbl_pix_valid", int'(bus.pix_valid), t.ev);
        chk("tbl_pix_out", int'(bus.pix_out), t.ep);
    endtask

    // Asynchronous reset between clock edges.
    task automatic mid_reset();
        #2 RST = 1'b1;
        #1;
        chk("rst_async_valid", int'(bus.pix_valid), 0);
        chk("rst_async_pix", int'(bus.pix_out), 0);
        chk("rst_async_addr", int'(bus.mem_addr), 0);
        model_clear();
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        int cnt;
        int px, py, h, v;
        logic fs, fl, en;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) mem[i] = TRANSPARENT;
        end
        mem[0] = GRN; mem[31] = GRN; mem[1023] = GRN;
        mem[27] = TRANSPARENT; mem[1011] = BLU; mem[3] = RED;
        for (int i = 320; i <= 330; i++) mem[i] = GRN;

        tbl.push_back('{1'b1, 100,   50, 1'b0,  100,   50, 1'b1,    0, 1, GRN});
        tbl.push_back('{1'b0, 100,   50, 1'b0,  131,   81, 1'b1, 1023, 1, GRN});
        tbl.push_back('{1'b0, 100,   50, 1'b0,   99,   50, 1'b1, 1023, 0, 0});
        tbl.push_back('{1'b0, 100,   50, 1'b0,  132,   50, 1'b1, 1023, 0, 0});
        tbl.push_back('{1'b0, 100,   50, 1'b0,  100,   82, 1'b1, 1023, 0, 0});
        tbl.push_back('{1'b0, 100,   50, 1'b0,  100,   50, 1'b0, 1023, 0, 0});
        tbl.push_back('{1'b1, 100,   50, 1'b1,  100,   50, 1'b1,   31, 1, GRN});
        tbl.push_back('{1'b0, 100,   50, 1'b1,  131,   50, 1'b1,    0, 1, GRN});
        tbl.push_back('{1'b0, 100,   50, 1'b1,  104,   50, 1'b1,   27, 0, 0});
        tbl.push_back('{1'b1, 100,   50, 1'b0,  100,   50, 1'b1,    0, 1, GRN});
        tbl.push_back('{1'b0, 300,   50, 1'b0,  131,   81, 1'b1, 1023, 1, GRN});
        tbl.push_back('{1'b0, 300,   50, 1'b0,  300,   50, 1'b1, 1023, 0, 0});
        tbl.push_back('{1'b1, 620,   10, 1'b0,  620,   10, 1'b1,    0, 1, GRN});
        tbl.push_back('{1'b0, 620,   10, 1'b0,  639,   41, 1'b1, 1011, 1, BLU});
        tbl.push_back('{1'b0, 620,   10, 1'b0,    0,   10, 1'b1, 1011, 0, 0});
        tbl.push_back('{1'b0, 620,   10, 1'b0,   11,   10, 1'b1, 1011, 0, 0});
        tbl.push_back('{1'b1, 1020, 1000, 1'b0, 1023, 1000, 1'b1,    3, 1, RED});
        tbl.push_back('{1'b0, 1020, 1000, 1'b0,    0, 1000, 1'b1,    3, 0, 0});
        tbl.push_back('{1'b0, 1020, 1000, 1'b0, 1020,    0, 1'b1,    3, 0, 0});

        // Reset state.
        RST = 1'b1;
        frame_start = 1'b0; pos_x = 10'd100; pos_y = 10'd50; flip_x = 1'b0;
        h_cnt = '0; v_cnt = '0; pix_en = 1'b0;
        model_clear();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("reset_mem_addr", int'(bus.mem_addr), 0);
        chk("reset_pix_valid", int'(bus.pix_valid), 0);
        chk("reset_pix_out", int'(bus.pix_out), 0);
        RST = 1'b0;

        // Raster sweep over the frog area before any frame_start.
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            run_cycle(1'b0, 100, 50, 1'b0, 96 + (i % 40), 48 + (i / 40) * 8, 1'b1);
            if (bus.pix_valid) cnt++;
        end
        chk("unarmed_valid_count", cnt, 0);

        foreach (tbl[i]) probe(tbl[i]);

        // frame_start in a hit cycle uses the old position.
        run_cycle(1'b1, 100, 50, 1'b0, 0, 0, 1'b0);
        run_cycle(1'b1, 500, 500, 1'b0, 131, 81, 1'b1);
        chk("fs_hit_old_addr", int'(bus.mem_addr), 1023);
        run_cycle(1'b0, 500, 500, 1'b0, 100, 50, 1'b1);
        chk("fs_next_new_pos_addr", int'(bus.mem_addr), 1023);
        run_cycle(1'b0, 500, 500, 1'b0, 0, 0, 1'b0);
        chk("fs_hit_old_valid", int'(bus.pix_valid), 1);
        chk("fs_hit_old_pix", int'(bus.pix_out), int'(GRN));
        run_cycle(1'b0, 500, 500, 1'b0, 0, 0, 1'b0);
        chk("fs_next_no_hit_valid", int'(bus.pix_valid), 0);

        // Reset mid-line while opaque pixels are streaming.
        run_cycle(1'b1, 100, 50, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 100, 50, 1'b0, 100 + i, 60, 1'b1);
        chk("pre_reset_valid", int'(bus.pix_valid), 1);
        mid_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'b0, 100, 50, 1'b0, 96 + i, 60, 1'b1);
            if (bus.pix_valid) cnt++;
        end
        chk("post_reset_valid_count", cnt, 0);

        // Random raster, mostly around the latched frog position.
        for (int i = 0; i < 4000; i++) begin
            fs = ($urandom_range(0, 49) == 0);
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            fl = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0) begin
                h = m_lx + int'($urandom_range(0, 40)) - 4;
                v = m_ly + int'($urandom_range(0, 40)) - 4;
            end else begin
                h = int'($urandom_range(0, 1023));
                v = int'($urandom_range(0, 1023));
            end
            run_cycle(fs, px, py, fl, h, v, en);
            if (i == 2500) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_frog.md
Name: sprite_fetch_frog

Overview:
- Read-side client of the frog sprite memory (1024 x 9-bit, 32x32 pixels, synchronous read, 1-cycle latency).
- Takes the raster position from the video timing generator and the frog position from game logic.
- Issues sprite-memory addresses and returns an aligned, transparency-keyed RGB pixel plus a valid flag to the pixel mixer.
- Frog position and orientation are latched once per frame to prevent tearing.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- ADDR_W, 10, sprite memory address width (log2(SPRITE_W*SPRITE_H))
- COORD_W, 10, screen coordinate width
- TRANSPARENT, 9'b111000111, colour key treated as "no pixel"

Ports:
- CLK  in  1  pixel clock
- RST  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- pos_x  in  COORD_W  frog left edge, screen pixels
- pos_y  in  COORD_W  frog top edge, screen pixels
- flip_x  in  1  mirror the sprite horizontally (frog facing left)
- h_cnt  in  COORD_W  current raster column
- v_cnt  in  COORD_W  current raster row
- pix_en  in  1  raster is in the active video area
- mem_addr  out  ADDR_W  address to sprite memory (registered)
- mem_data  in  9  sprite memory read data, valid 1 cycle after mem_addr
- pix_out  out  9  RGB333 pixel, aligned with pix_valid
- pix_valid  out  1  1 = opaque sprite pixel at this raster position

Behaviour:
- Reset: mem_addr=0, pix_out=0, pix_valid=0, latched x/y=0, latched flip=0, armed=0. All pipeline valid bits are cleared.
- Frame latch: on a frame_start cycle, latched x/y/flip <= pos_x/pos_y/flip_x and armed <= 1. Outside frame_start, changes to pos_x/pos_y/flip_x are ignored.
- While armed=0 (reset until the first frame_start), pix_valid stays 0.
- Hit test at stage 0, computed with COORD_W+1-bit sums so there is no wrap:
  - hit = armed & pix_en & (h_cnt >= lx) & (h_cnt < lx+SPRITE_W) & (v_cnt >= ly) & (v_cnt < ly+SPRITE_H)
  - col = h_cnt-lx; if flip, col = SPRITE_W-1-col; row = v_cnt-ly (both truncated to log2 widths).
- Stage 1 (clock edge after inputs):
  - If hit, mem_addr <= row*SPRITE_W + col (concatenation {row,col}).
  - If not hit, mem_addr holds its previous value.
  - hit_d1 <= hit.
- Stage 2: mem_data becomes valid; hit_d2 <= hit_d1.
- Stage 3 (registered output):
  - pix_valid <= hit_d2 & (mem_data != TRANSPARENT)
  - pix_out <= mem_data when that condition holds, else 0.
- Latency: fixed 3 CLK cycles from h_cnt/v_cnt to pix_out/pix_valid. The mixer delays its own raster by 3 to stay aligned.
- One result per cycle, no stalls, no backpressure.
- frame_start coinciding with a hit cycle: the hit test in that cycle uses the old latched values; new values apply from the next cycle.
- Clipping: sprite parts beyond the right or bottom screen edge are never rasterised. pos_x up to 1023 does not wrap onto the left edge.
- Reset mid-frame: all outputs return to reset values asynchronously. Output stays invisible until the next frame_start.

Decomposition:
- Shared package (sprite_pkg): SPRITE_W, SPRITE_H, ADDR_W, COLOR_W=9, TRANSPARENT key, and the RGB333 field offsets.
- One natural sub-module: sprite_hit_calc, a combinational hit/row/col/flip computation reusable by the car and log fetchers.

Test Plan:
- Reset then raster sweep with no frame_start, pos=(100,50) -> pix_valid=0 on every cycle.
- frame_start with pos=(100,50), flip=0; raster (100,50) -> mem_addr=0 after 1 cycle. Raster (131,81) -> mem_addr=1023. With mem_data=9'b000111000, pix_out=9'b000111000 and pix_valid=1 exactly 3 cycles after each input.
- Same position with flip=1; raster (100,50) -> mem_addr=31. Raster (131,50) -> mem_addr=0.
- Memory returns TRANSPARENT at a hit -> pix_valid=0, pix_out=0. Raster (99,50) or (132,50) -> no hit, mem_addr unchanged.
- pos_x=620 latched; raster h_cnt 620..639 -> hits; h_cnt 0..11 on the same row -> no hit (no wrap).
- Change pos_x to 300 mid-frame -> output still at x=100 until the next frame_start. Assert RST mid-line -> pix_valid=0 immediately and stays 0 until frame_start.
